// File: rtl/cmip_sfifo_wd_conv.sv
// cmip_sfifo_wd_conv: synchronous narrow-to-wide packing FIFO.
// Narrow write beats are packed into RATE-slot words that go into a word store.
// A partially filled word can be pushed early with i_flush.
// The build-time macro CMIP_SFIFO_WD_CONV_FWFT_EN selects the read style:
//   defined   : first-word-fall-through (the head word is always on o_dout)
//   undefined : registered read (o_dout updates one cycle after an accepted i_rd)
module cmip_sfifo_wd_conv #(
   parameter int DPTH       = 32,
   parameter int WR_DATA_WD = 128,
   parameter int RD_DATA_WD = 512,
   parameter int FIRST_MSB  = 1,
   parameter int AFUL_TH    = 4,
   parameter int ADDR_WD    = $clog2(DPTH),
   parameter int CNT_WD     = $clog2(RD_DATA_WD / WR_DATA_WD + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr,
   input  logic [WR_DATA_WD-1:0] i_din,
   input  logic                  i_flush,
   output logic                  o_full,
   output logic                  o_aful,
   output logic [CNT_WD-1:0]     o_pack_cnt,
   output logic [ADDR_WD:0]      o_word_cnt,
   input  logic                  i_rd,
   output logic [RD_DATA_WD-1:0] o_dout,
   output logic [CNT_WD-1:0]     o_vld_cnt,
   output logic                  o_empty,
   output logic                  o_ovfl,
   output logic                  o_unfl
);

   localparam int                RATE      = RD_DATA_WD / WR_DATA_WD;
   localparam logic [CNT_WD-1:0] LAST_SLOT = CNT_WD'(RATE - 1);
   localparam logic [ADDR_WD:0]  FULL_CNT  = (ADDR_WD + 1)'(DPTH);
   localparam logic [ADDR_WD:0]  AFUL_CNT  = (ADDR_WD + 1)'(DPTH - AFUL_TH);

   logic [RD_DATA_WD-1:0] pack_q, pack_d, merged;
   logic [CNT_WD-1:0]     pack_cnt_q, pack_cnt_d, slot, push_vld;
   logic                  accept, complete, push, pop;

   logic [RD_DATA_WD-1:0] mem_q     [DPTH];
   logic [CNT_WD-1:0]     vld_mem_q [DPTH];
   logic [ADDR_WD-1:0]    wr_ptr_q, rd_ptr_q;
   logic [ADDR_WD:0]      word_cnt_q, word_cnt_d;
   logic                  ovfl_q, unfl_q;

   assign o_full     = (word_cnt_q == FULL_CNT);
   assign o_empty    = (word_cnt_q == '0);
   assign o_aful     = (word_cnt_q >= AFUL_CNT);
   assign o_word_cnt = word_cnt_q;
   assign o_pack_cnt = pack_cnt_q;
   assign o_ovfl     = ovfl_q;
   assign o_unfl     = unfl_q;

   assign accept   = i_wr && !o_full;
   assign pop      = i_rd && !o_empty;
   assign complete = accept && (pack_cnt_q == LAST_SLOT);
   // A flush counts a beat accepted in the same cycle; a completing beat already pushes.
   assign push     = complete || (i_flush && (accept || (pack_cnt_q != '0)));
   assign push_vld = accept ? (pack_cnt_q + CNT_WD'(1)) : pack_cnt_q;

   // Slot selection and merge of the incoming beat into the packing word
   always_comb begin
      if (FIRST_MSB != 0) slot = LAST_SLOT - pack_cnt_q;
      else                slot = pack_cnt_q;
      merged = pack_q;
      for (int s = 0; s < RATE; s++) begin
         if (accept && (slot == CNT_WD'(s))) merged[s*WR_DATA_WD +: WR_DATA_WD] = i_din;
      end
   end

   // Packer next state; clearing on push leaves unfilled slots of the next word zero
   always_comb begin
      pack_d     = pack_q;
      pack_cnt_d = pack_cnt_q;
      if (push) begin
         pack_d     = '0;
         pack_cnt_d = '0;
      end else if (accept) begin
         pack_d     = merged;
         pack_cnt_d = pack_cnt_q + CNT_WD'(1);
      end
   end

   // Word count next state; push and pop together leave it unchanged
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (push && !pop)      word_cnt_d = word_cnt_q + 1'b1;
      else if (pop && !push) word_cnt_d = word_cnt_q - 1'b1;
   end

   // Control state: packer, pointers, count and sticky error flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pack_q     <= '0;
         pack_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         word_cnt_q <= '0;
         ovfl_q     <= 1'b0;
         unfl_q     <= 1'b0;
      end else begin
         pack_q     <= pack_d;
         pack_cnt_q <= pack_cnt_d;
         word_cnt_q <= word_cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (i_wr && o_full)  ovfl_q <= 1'b1;
         if (i_rd && o_empty) unfl_q <= 1'b1;
      end
   end

   // Word store; contents need no reset since the count gates every read
   always_ff @(posedge i_clk) begin
      if (push && !i_rst) begin
         mem_q[wr_ptr_q]     <= merged;
         vld_mem_q[wr_ptr_q] <= push_vld;
      end
   end

`ifdef CMIP_SFIFO_WD_CONV_FWFT_EN
   assign o_dout    = o_empty ? '0 : mem_q[rd_ptr_q];
   assign o_vld_cnt = o_empty ? '0 : vld_mem_q[rd_ptr_q];
`else
   logic [RD_DATA_WD-1:0] dout_q;
   logic [CNT_WD-1:0]     vld_cnt_q;

   // Registered read port: capture the head word on an accepted read, hold otherwise
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dout_q    <= '0;
         vld_cnt_q <= '0;
      end else if (pop) begin
         dout_q    <= mem_q[rd_ptr_q];
         vld_cnt_q <= vld_mem_q[rd_ptr_q];
      end
   end

   assign o_dout    = dout_q;
   assign o_vld_cnt = vld_cnt_q;
`endif

endmodule

// File: tb/tb_cmip_sfifo_wd_conv.sv
// Bench for cmip_sfifo_wd_conv: two instances (MSB-first and LSB-first packing)
// share all inputs and are compared every cycle against a queue-based model.
module tb_cmip_sfifo_wd_conv;

   localparam int WR = 32;
   localparam int RD = 128;
   localparam int DP = 4;
   localparam int RT = RD / WR;

   logic            clk = 1'b0;
   logic            rst = 1'b0, wr = 1'b0, flush = 1'b0, rd = 1'b0;
   logic [WR-1:0]   din = '0;
   logic            full_m, aful_m, empty_m, ovfl_m, unfl_m;
   logic            full_l, aful_l, empty_l, ovfl_l, unfl_l;
   logic [2:0]      pcnt_m, pcnt_l, vld_m, vld_l;
   logic [2:0]      wcnt_m, wcnt_l;
   logic [RD-1:0]   dout_m, dout_l;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   cmip_sfifo_wd_conv #(.DPTH(DP), .WR_DATA_WD(WR), .RD_DATA_WD(RD), .FIRST_MSB(1), .AFUL_TH(1)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_din(din), .i_flush(flush),
      .o_full(full_m), .o_aful(aful_m), .o_pack_cnt(pcnt_m), .o_word_cnt(wcnt_m),
      .i_rd(rd), .o_dout(dout_m), .o_vld_cnt(vld_m), .o_empty(empty_m),
      .o_ovfl(ovfl_m), .o_unfl(unfl_m));

   cmip_sfifo_wd_conv #(.DPTH(DP), .WR_DATA_WD(WR), .RD_DATA_WD(RD), .FIRST_MSB(0), .AFUL_TH(1)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_din(din), .i_flush(flush),
      .o_full(full_l), .o_aful(aful_l), .o_pack_cnt(pcnt_l), .o_word_cnt(wcnt_l),
      .i_rd(rd), .o_dout(dout_l), .o_vld_cnt(vld_l), .o_empty(empty_l),
      .o_ovfl(ovfl_l), .o_unfl(unfl_l));

   // ---------------- reference model ----------------
   logic [WR-1:0] pend [RT];
   int            pend_n = 0;
   logic [RD-1:0] q_m [$];
   logic [RD-1:0] q_l [$];
   int            q_v [$];
   logic [RD-1:0] r_dout_m = '0, r_dout_l = '0;
   int            r_vld = 0;
   bit            m_ovfl = 0, m_unfl = 0;

   task automatic model_step(input logic r, input logic w, input logic [WR-1:0] d,
                             input logic f, input logic rr);
      logic [RD-1:0] wm, wl;
      bit is_full, is_empty, do_push;
      if (r) begin
         pend_n = 0; q_m.delete(); q_l.delete(); q_v.delete();
         r_dout_m = '0; r_dout_l = '0; r_vld = 0; m_ovfl = 0; m_unfl = 0;
         return;
      end
      is_full  = (q_m.size() == DP);
      is_empty = (q_m.size() == 0);
      if (w && is_full)   m_ovfl = 1;
      if (rr && is_empty) m_unfl = 1;
      if (w && !is_full) begin
         pend[pend_n] = d;
         pend_n++;
      end
      do_push = (pend_n == RT) || (f && pend_n > 0);
      if (rr && !is_empty) begin
         r_dout_m = q_m.pop_front();
         r_dout_l = q_l.pop_front();
         r_vld    = q_v.pop_front();
      end
      if (do_push) begin
         wm = '0; wl = '0;
         for (int k = 0; k < pend_n; k++) begin
            wm[(RT-1-k)*WR +: WR] = pend[k];
            wl[k*WR +: WR]        = pend[k];
         end
         q_m.push_back(wm); q_l.push_back(wl); q_v.push_back(pend_n);
         pend_n = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [RD-1:0] act, input logic [RD-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      int sz;
      logic [RD-1:0] em, el;
      int ev;
      sz = q_m.size();
`ifdef CMIP_SFIFO_WD_CONV_FWFT_EN
      em = (sz > 0) ? q_m[0] : '0;
      el = (sz > 0) ? q_l[0] : '0;
      ev = (sz > 0) ? q_v[0] : 0;
`else
      em = r_dout_m; el = r_dout_l; ev = r_vld;
`endif
      chk("pack_cnt", RD'(pcnt_m), RD'(pend_n));
      chk("word_cnt", RD'(wcnt_m), RD'(sz));
      chk("empty",    RD'(empty_m), RD'(sz == 0));
      chk("full",     RD'(full_m),  RD'(sz == DP));
      chk("aful",     RD'(aful_m),  RD'(sz >= DP - 1));
      chk("ovfl",     RD'(ovfl_m),  RD'(m_ovfl));
      chk("unfl",     RD'(unfl_m),  RD'(m_unfl));
      chk("dout_msb", dout_m, em);
      chk("dout_lsb", dout_l, el);
      chk("vld_msb",  RD'(vld_m), RD'(ev));
      chk("vld_lsb",  RD'(vld_l), RD'(ev));
      chk("lsb_flags", RD'({full_l, aful_l, empty_l, ovfl_l, unfl_l, pcnt_l, wcnt_l}),
                       RD'({full_m, aful_m, empty_m, ovfl_m, unfl_m, pcnt_m, wcnt_m}));
   endtask

   task automatic step(input logic r, input logic w, input logic [WR-1:0] d,
                       input logic f, input logic rr);
      rst = r; wr = w; din = d; flush = f; rd = rr;
      @(posedge clk);
      model_step(r, w, d, f, rr);
      cyc++;
      #1;
      rst = 0; wr = 0; flush = 0; rd = 0;
      check_all();
   endtask

   // Read one word and compare it with fixed expected values at the right latency.
   task automatic read_word(input string nm, input logic [RD-1:0] em, input logic [RD-1:0] el, input int ev);
`ifdef CMIP_SFIFO_WD_CONV_FWFT_EN
      chk({nm, "_msb"}, dout_m, em);
      chk({nm, "_lsb"}, dout_l, el);
      chk({nm, "_vld"}, RD'(vld_m), RD'(ev));
      step(0, 0, '0, 0, 1);
`else
      step(0, 0, '0, 0, 1);
      chk({nm, "_msb"}, dout_m, em);
      chk({nm, "_lsb"}, dout_l, el);
      chk({nm, "_vld"}, RD'(vld_m), RD'(ev));
`endif
   endtask

   typedef struct {
      logic          rst;
      logic          wr;
      logic [WR-1:0] din;
      int            exp_pack;
      int            exp_word;
      logic          exp_full;
      logic          exp_aful;
      logic          exp_ovfl;
   } vec_t;

   vec_t tbl [18];

   initial begin
      // Fill sequence: reset, 16 beats filling the store, a 17th beat that is dropped.
      tbl[0] = '{rst:1, wr:0, din:'0, exp_pack:0, exp_word:0, exp_full:0, exp_aful:0, exp_ovfl:0};
      for (int i = 0; i < 16; i++)
         tbl[i+1] = '{rst:0, wr:1, din:32'h100 + i, exp_pack:(i+1) % 4, exp_word:(i+1) / 4,
                      exp_full:((i+1)/4 == 4), exp_aful:((i+1)/4 >= 3), exp_ovfl:0};
      tbl[17] = '{rst:0, wr:1, din:32'hDEAD, exp_pack:0, exp_word:4, exp_full:1, exp_aful:1, exp_ovfl:1};

      // Reset values
      step(1, 0, '0, 0, 0);
      chk("rst_empty", RD'(empty_m), RD'(1));
      chk("rst_dout",  dout_m, '0);

      // MSB-first packing of four beats
      step(0, 1, 32'hA, 0, 0);
      step(0, 1, 32'hB, 0, 0);
      step(0, 1, 32'hC, 0, 0);
      chk("empty_before_push", RD'(empty_m), RD'(1));
      step(0, 1, 32'hD, 0, 0);
      chk("empty_after_push", RD'(empty_m), RD'(0));
      read_word("word_abcd", 128'h0000000A_0000000B_0000000C_0000000D,
                             128'h0000000D_0000000C_0000000B_0000000A, 4);

      // Partial word via flush
      step(0, 1, 32'h1, 0, 0);
      step(0, 1, 32'h2, 0, 0);
      step(0, 0, '0, 1, 0);
      chk("flush_pack_cnt", RD'(pcnt_m), RD'(0));
      read_word("word_flush", 128'h00000001_00000002_00000000_00000000,
                              128'h00000000_00000000_00000002_00000001, 2);
      step(0, 0, '0, 1, 0);   // flush with nothing pending: ignored

      // Table-driven fill to full, then overflow
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].rst, tbl[i].wr, tbl[i].din, 0, 0);
         chk($sformatf("tbl%0d_pack", i), RD'(pcnt_m), RD'(tbl[i].exp_pack));
         chk($sformatf("tbl%0d_word", i), RD'(wcnt_m), RD'(tbl[i].exp_word));
         chk($sformatf("tbl%0d_full", i), RD'(full_m), RD'(tbl[i].exp_full));
         chk($sformatf("tbl%0d_aful", i), RD'(aful_m), RD'(tbl[i].exp_aful));
         chk($sformatf("tbl%0d_ovfl", i), RD'(ovfl_m), RD'(tbl[i].exp_ovfl));
      end

      // Full store: read and write together -> pop, beat dropped
      step(0, 1, 32'hBEEF, 0, 1);
      chk("rdwr_full_word_cnt", RD'(wcnt_m), RD'(3));
      chk("rdwr_full_full",     RD'(full_m), RD'(0));
      chk("rdwr_full_pack",     RD'(pcnt_m), RD'(0));
      read_word("stored_w1", 128'h00000104_00000105_00000106_00000107,
                             128'h00000107_00000106_00000105_00000104, 4);
      step(0, 0, '0, 0, 1);
      step(0, 0, '0, 0, 1);
      step(0, 0, '0, 0, 1);   // read while empty
      chk("unfl_after_drain", RD'(unfl_m), RD'(1));

      // Reset mid-word discards packed beats
      step(1, 0, '0, 0, 0);
      step(0, 1, 32'h55, 0, 0);
      step(0, 1, 32'h66, 0, 0);
      step(1, 0, '0, 0, 0);
      chk("midrst_pack", RD'(pcnt_m), RD'(0));
      chk("midrst_empty", RD'(empty_m), RD'(1));
      step(0, 0, '0, 1, 1);
      chk("midrst_unfl", RD'(unfl_m), RD'(1));
      chk("midrst_no_word", RD'(wcnt_m), RD'(0));

      // Three words queued, back-to-back reads
      for (int i = 0; i < 12; i++) step(0, 1, 32'h30 + i, 0, 0);
      read_word("b2b_w0", 128'h00000030_00000031_00000032_00000033,
                          128'h00000033_00000032_00000031_00000030, 4);
      read_word("b2b_w1", 128'h00000034_00000035_00000036_00000037,
                          128'h00000037_00000036_00000035_00000034, 4);
      read_word("b2b_w2", 128'h00000038_00000039_0000003A_0000003B,
                          128'h0000003B_0000003A_00000039_00000038, 4);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         int rd_bias;
         rd_bias = ((i / 150) % 2 == 0) ? 5 : 1;
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 3) != 0,
              $urandom,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, rd_bias) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
